tl_bram_adapter: RTL and testbench

TileLink-UL slave front-end that drives the 512x32 byte-masked simple dual-port BRAM (1-cycle registered read). Converts single-beat A-channel Get/PutFullData/PutPartialData into BRAM read/write port activity and returns D-channel AccessAck/AccessAckData. Full throughput: one transaction per cycle when the D sink is ready. At most one response is pending at any time.

---
 rtl/tl_bram_adapter.sv | 133 +++++++++++++
 tb/tb_tl_bram_adapter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_bram_adapter.sv
// TileLink-UL slave front-end for a 512x32 byte-masked BRAM with a 1-cycle registered read.
// Single-beat Get/PutFullData/PutPartialData map onto the BRAM ports; at most one D response is pending.
module tl_bram_adapter #(
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [2:0]        a_opcode_i,
    input  logic [2:0]        a_param_i,
    input  logic [2:0]        a_size_i,
    input  logic [SRC_W-1:0]  a_source_i,
    input  logic [ADDR_W-1:0] a_address_i,
    input  logic [3:0]        a_mask_i,
    input  logic [31:0]       a_data_i,
    input  logic              a_corrupt_i,
    output logic              d_valid_o,
    input  logic              d_ready_i,
    output logic [2:0]        d_opcode_o,
    output logic [1:0]        d_param_o,
    output logic [2:0]        d_size_o,
    output logic [SRC_W-1:0]  d_source_o,
    output logic              d_denied_o,
    output logic [31:0]       d_data_o,
    output logic              d_corrupt_o,
    output logic [8:0]        rd_addr_o,
    input  logic [31:0]       rd_data_i,
    output logic              wr_en_o,
    output logic [8:0]        wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic [3:0]        wr_bm_o
);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_ARITH    = 3'd2;
    localparam logic [2:0] OP_LOGIC    = 3'd3;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_INTENT   = 3'd5;

    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK = 3'd2;

    logic             r_d_valid;
    logic [2:0]       r_d_opcode;
    logic [2:0]       r_d_size;
    logic [SRC_W-1:0] r_d_source;
    logic             r_d_denied;
    logic             r_d_is_get;
    logic [8:0]       r_addr_q;

    logic       w_a_ready;
    logic       w_a_fire;
    logic       w_is_put;
    logic       w_is_get;
    logic       w_aligned;
    logic       w_legal;
    logic [2:0] w_d_opcode;
    logic       w_unused;

    assign w_a_ready = !r_d_valid || d_ready_i;
    assign w_a_fire  = a_valid_i && w_a_ready;
    assign w_is_put  = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PART);
    assign w_is_get  = (a_opcode_i == OP_GET);

    always_comb begin
        w_aligned = 1'b0;
        case (a_size_i)
            3'd0:    w_aligned = 1'b1;
            3'd1:    w_aligned = !a_address_i[0];
            3'd2:    w_aligned = (a_address_i[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    // Corrupt write data is refused rather than committed to the array.
    assign w_legal = ((w_is_put && !a_corrupt_i) || w_is_get) && w_aligned;

    always_comb begin
        w_d_opcode = D_ACK;
        case (a_opcode_i)
            OP_GET, OP_ARITH, OP_LOGIC: w_d_opcode = D_ACK_DATA;
            OP_INTENT:                  w_d_opcode = D_HINT_ACK;
            default:                    w_d_opcode = D_ACK;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_d_valid  <= 1'b0;
            r_d_opcode <= D_ACK;
            r_d_size   <= 3'd0;
            r_d_source <= '0;
            r_d_denied <= 1'b0;
            r_d_is_get <= 1'b0;
            r_addr_q   <= 9'd0;
        end else if (w_a_fire) begin
            r_d_valid  <= 1'b1;
            r_d_opcode <= w_d_opcode;
            r_d_size   <= a_size_i;
            r_d_source <= a_source_i;
            r_d_denied <= !w_legal;
            r_d_is_get <= w_is_get && w_legal;
            r_addr_q   <= a_address_i[10:2];
        end else if (r_d_valid && d_ready_i) begin
            r_d_valid  <= 1'b0;
        end
    end

    // While a response stalls, the read port re-reads the captured word so rd_data_i stays put.
    assign rd_addr_o = w_a_ready ? a_address_i[10:2] : r_addr_q;

    assign wr_en_o   = w_a_fire && w_legal && w_is_put;
    assign wr_addr_o = a_address_i[10:2];
    assign wr_data_o = a_data_i;
    assign wr_bm_o   = a_mask_i;

    assign a_ready_o   = w_a_ready;
    assign d_valid_o   = r_d_valid;
    assign d_opcode_o  = r_d_opcode;
    assign d_param_o   = 2'd0;
    assign d_size_o    = r_d_size;
    assign d_source_o  = r_d_source;
    assign d_denied_o  = r_d_denied;
    assign d_data_o    = (r_d_valid && r_d_is_get) ? rd_data_i : 32'd0;
    assign d_corrupt_o = r_d_valid && r_d_denied && (r_d_opcode == D_ACK_DATA);

    assign w_unused = ^{a_param_i, a_address_i[ADDR_W-1:11]};

endmodule

// File: tb/tb_tl_bram_adapter.sv
// Bench for tl_bram_adapter: BRAM stub, reference memory/response model checked every cycle,
// plus directed sequences with literal expectations.
module tb_tl_bram_adapter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        a_valid_i;
    logic        a_ready_o;
    logic [2:0]  a_opcode_i;
    logic [2:0]  a_param_i;
    logic [2:0]  a_size_i;
    logic [3:0]  a_source_i;
    logic [31:0] a_address_i;
    logic [3:0]  a_mask_i;
    logic [31:0] a_data_i;
    logic        a_corrupt_i;
    logic        d_valid_o;
    logic        d_ready_i;
    logic [2:0]  d_opcode_o;
    logic [1:0]  d_param_o;
    logic [2:0]  d_size_o;
    logic [3:0]  d_source_o;
    logic        d_denied_o;
    logic [31:0] d_data_o;
    logic        d_corrupt_o;
    logic [8:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic        wr_en_o;
    logic [8:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_bm_o;

    always #5 clk = ~clk;

    tl_bram_adapter #(.ADDR_W(32), .SRC_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
        .a_param_i(a_param_i), .a_size_i(a_size_i), .a_source_i(a_source_i),
        .a_address_i(a_address_i), .a_mask_i(a_mask_i), .a_data_i(a_data_i),
        .a_corrupt_i(a_corrupt_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
        .d_param_o(d_param_o), .d_size_o(d_size_o), .d_source_o(d_source_o),
        .d_denied_o(d_denied_o), .d_data_o(d_data_o), .d_corrupt_o(d_corrupt_o),
        .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_bm_o(wr_bm_o)
    );

    // BRAM stub: read-first, registered read, byte-masked write.
    logic [31:0] mem [512];
    logic [31:0] bram_q;
    bit          bram_init = 1'b0;
    assign rd_data_i = bram_q;

    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA500_0000 | i;
            bram_init <= 1'b1;
        end else if (wr_en_o) begin
            for (int b = 0; b < 4; b++)
                if (wr_bm_o[b]) mem[wr_addr_o][8*b +: 8] <= wr_data_o[8*b +: 8];
        end
        bram_q <= mem[rd_addr_o];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents and the single pending response.
    logic [31:0] ref_mem [512];
    bit          model_on = 1'b0;
    bit          exp_valid;
    logic [2:0]  exp_op;
    logic [2:0]  exp_size;
    logic [3:0]  exp_src;
    bit          exp_denied;
    logic [31:0] exp_data;

    function automatic bit legal_req(input logic [2:0] op, input logic [2:0] size,
                                     input logic [31:0] addr, input logic corrupt);
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b0;
        if (size > 3'd2) return 1'b0;
        if ((addr % (32'd1 << size)) != 0) return 1'b0;
        if (op != 3'd4 && corrupt) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [2:0] resp_op(input logic [2:0] op);
        if (op == 3'd4 || op == 3'd2 || op == 3'd3) return 3'd1;
        if (op == 3'd5) return 3'd2;
        return 3'd0;
    endfunction

    task automatic model_cycle();
        bit          rdy, fire, lg, put, wr;
        logic [8:0]  w;
        rdy  = !exp_valid || d_ready_i;
        fire = a_valid_i && rdy;
        lg   = legal_req(a_opcode_i, a_size_i, a_address_i, a_corrupt_i);
        put  = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
        wr   = fire && lg && put;
        w    = a_address_i[10:2];
        if (model_on) begin
            chk("a_ready", {31'd0, a_ready_o}, {31'd0, rdy});
            chk("d_valid", {31'd0, d_valid_o}, {31'd0, exp_valid});
            if (exp_valid) begin
                chk("d_opcode",  {29'd0, d_opcode_o}, {29'd0, exp_op});
                chk("d_size",    {29'd0, d_size_o},   {29'd0, exp_size});
                chk("d_source",  {28'd0, d_source_o}, {28'd0, exp_src});
                chk("d_denied",  {31'd0, d_denied_o}, {31'd0, exp_denied});
                chk("d_data",    d_data_o, exp_data);
                chk("d_corrupt", {31'd0, d_corrupt_o}, {31'd0, exp_denied && exp_op == 3'd1});
                chk("d_param",   {30'd0, d_param_o}, 32'd0);
            end
            if (!rst_i) begin
                chk("wr_en", {31'd0, wr_en_o}, {31'd0, wr});
                if (wr) begin
                    chk("wr_addr", {23'd0, wr_addr_o}, {23'd0, w});
                    chk("wr_data", wr_data_o, a_data_i);
                    chk("wr_bm",   {28'd0, wr_bm_o}, {28'd0, a_mask_i});
                end
            end
        end
        if (rst_i) begin
            model_on   = 1'b1;
            exp_valid  = 1'b0;
            exp_op     = 3'd0;
            exp_size   = 3'd0;
            exp_src    = 4'd0;
            exp_denied = 1'b0;
            exp_data   = 32'd0;
        end else if (fire) begin
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (a_mask_i[b]) ref_mem[w][8*b +: 8] = a_data_i[8*b +: 8];
            exp_valid  = 1'b1;
            exp_op     = resp_op(a_opcode_i);
            exp_size   = a_size_i;
            exp_src    = a_source_i;
            exp_denied = !lg;
            exp_data   = (lg && a_opcode_i == 3'd4) ? ref_mem[w] : 32'd0;
        end else if (exp_valid && d_ready_i) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [3:0] src,
                           input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input logic corrupt);
        a_valid_i   = 1'b1;
        a_opcode_i  = op;
        a_size_i    = size;
        a_source_i  = src;
        a_address_i = addr;
        a_mask_i    = mask;
        a_data_i    = data;
        a_corrupt_i = corrupt;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'hA500_0000 | i;
        rst_i = 1'b1; a_valid_i = 1'b0; a_opcode_i = 3'd0; a_param_i = 3'd0;
        a_size_i = 3'd0; a_source_i = 4'd0; a_address_i = 32'd0; a_mask_i = 4'd0;
        a_data_i = 32'd0; a_corrupt_i = 1'b0; d_ready_i = 1'b1;
        repeat (3) step();
        chk("rst_d_valid",  {31'd0, d_valid_o}, 32'd0);
        chk("rst_d_opcode", {29'd0, d_opcode_o}, 32'd0);
        chk("rst_d_size",   {29'd0, d_size_o}, 32'd0);
        chk("rst_d_source", {28'd0, d_source_o}, 32'd0);
        chk("rst_d_denied", {31'd0, d_denied_o}, 32'd0);
        chk("rst_a_ready",  {31'd0, a_ready_o}, 32'd1);
        rst_i = 1'b0;
        step();

        // PutFull then Get of the same word
        drive_a(3'd0, 3'd2, 4'd1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        #1;
        chk("put_wr_en",   {31'd0, wr_en_o}, 32'd1);
        chk("put_wr_addr", {23'd0, wr_addr_o}, 32'd4);
        step();
        chk("put_ack_op", {29'd0, d_opcode_o}, 32'd0);
        drive_a(3'd4, 3'd2, 4'd2, 32'h10, 4'hF, 32'd0, 1'b0);
        step();
        chk("get_valid",  {31'd0, d_valid_o}, 32'd1);
        chk("get_op",     {29'd0, d_opcode_o}, 32'd1);
        chk("get_data",   d_data_o, 32'hDEADBEEF);
        chk("get_denied", {31'd0, d_denied_o}, 32'd0);

        // PutPartial over one byte lane
        drive_a(3'd1, 3'd2, 4'd3, 32'h10, 4'h2, 32'h0000AA00, 1'b0);
        step();
        drive_a(3'd4, 3'd2, 4'd3, 32'h10, 4'hF, 32'd0, 1'b0);
        step();
        chk("partial_data", d_data_o, 32'hDEADAAEF);
        drive_a(3'd0, 3'd2, 4'd4, 32'h20, 4'hF, 32'h12345678, 1'b0);
        step();
        a_valid_i = 1'b0;
        step();

        // Stalled Get: data must hold while the A address wanders
        d_ready_i = 1'b0;
        drive_a(3'd4, 3'd2, 4'd5, 32'h20, 4'hF, 32'd0, 1'b0);
        step();
        a_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_address_i = k[0] ? 32'h30 : 32'h10;
            #1;
            chk("stall_ready", {31'd0, a_ready_o}, 32'd0);
            chk("stall_data",  d_data_o, 32'h12345678);
            step();
        end
        d_ready_i = 1'b1;
        #1;
        chk("stall_release_valid", {31'd0, d_valid_o}, 32'd1);
        step();
        chk("stall_single_beat", {31'd0, d_valid_o}, 32'd0);

        // Eight back-to-back Gets
        for (int i = 0; i < 8; i++) begin
            drive_a(3'd4, 3'd2, i[3:0], 32'h100 + 32'(4 * i), 4'hF, 32'd0, 1'b0);
            step();
            chk("stream_valid",  {31'd0, d_valid_o}, 32'd1);
            chk("stream_source", {28'd0, d_source_o}, 32'(i));
            chk("stream_data",   d_data_o, 32'hA500_0000 | 32'(64 + i));
        end
        a_valid_i = 1'b0;
        step();

        // Illegal requests
        drive_a(3'd4, 3'd3, 4'd9, 32'h0, 4'hF, 32'd0, 1'b0);
        #1;
        chk("bad_get_wr_en", {31'd0, wr_en_o}, 32'd0);
        step();
        chk("bad_get_denied",  {31'd0, d_denied_o}, 32'd1);
        chk("bad_get_op",      {29'd0, d_opcode_o}, 32'd1);
        chk("bad_get_corrupt", {31'd0, d_corrupt_o}, 32'd1);
        chk("bad_get_data",    d_data_o, 32'd0);
        drive_a(3'd0, 3'd2, 4'd10, 32'h11, 4'hF, 32'hFFFFFFFF, 1'b0);
        #1;
        chk("misalign_put_wr_en", {31'd0, wr_en_o}, 32'd0);
        step();
        chk("misalign_put_denied",  {31'd0, d_denied_o}, 32'd1);
        chk("misalign_put_op",      {29'd0, d_opcode_o}, 32'd0);
        chk("misalign_put_corrupt", {31'd0, d_corrupt_o}, 32'd0);
        drive_a(3'd5, 3'd2, 4'd11, 32'h10, 4'hF, 32'hFFFFFFFF, 1'b0);
        #1;
        chk("intent_wr_en", {31'd0, wr_en_o}, 32'd0);
        step();
        chk("intent_op",      {29'd0, d_opcode_o}, 32'd2);
        chk("intent_denied",  {31'd0, d_denied_o}, 32'd1);
        chk("intent_corrupt", {31'd0, d_corrupt_o}, 32'd0);
        drive_a(3'd1, 3'd1, 4'd12, 32'h12, 4'hC, 32'h5555_0000, 1'b1);
        step();
        chk("corrupt_put_denied", {31'd0, d_denied_o}, 32'd1);
        drive_a(3'd4, 3'd1, 4'd13, 32'h13, 4'hF, 32'd0, 1'b0);
        step();
        chk("misalign_half_denied", {31'd0, d_denied_o}, 32'd1);
        drive_a(3'd4, 3'd0, 4'd14, 32'h13, 4'hF, 32'd0, 1'b0);
        step();
        chk("byte_get_denied", {31'd0, d_denied_o}, 32'd0);
        chk("byte_get_data",   d_data_o, 32'hDEADAAEF);
        a_valid_i = 1'b0;
        step();

        // Reset with a pending response
        d_ready_i = 1'b0;
        drive_a(3'd4, 3'd2, 4'd15, 32'h10, 4'hF, 32'd0, 1'b0);
        step();
        chk("pend_valid", {31'd0, d_valid_o}, 32'd1);
        a_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        chk("rst_drop_valid", {31'd0, d_valid_o}, 32'd0);
        rst_i = 1'b0;
        d_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_beat", {31'd0, d_valid_o}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
